// File: rtl/ddr_tx.sv
// rtl/ddr_tx.sv - HDR-DDR transmit serializer for the I3C controller data path
//
// Purpose: on SCL edge pulses, drives SDA with preamble bits, MSB-first data
// bytes, the two per-word parity bits, the CRC token and the 5-bit CRC value,
// as selected by the DDR CCC controller. Transmitted bytes are fed to the CRC
// block.
//
// Ports:
//   i_sys_clk               system clock
//   i_sys_rst               asynchronous active-low reset
//   i_sclgen_scl_pos_edge   one-cycle pulse per SCL rising edge
//   i_sclgen_scl_neg_edge   one-cycle pulse per SCL falling edge
//   i_ddrccc_tx_en          block enable
//   i_ddrccc_tx_mode        field to transmit (0..5 valid)
//   i_regf_tx_data          byte for SERIAL_BYTE
//   i_crc_value             CRC result for CRC_VALUE
//   o_sdahnd_tx_sda         serial bit to SDA handler
//   o_ddrccc_tx_mode_done   high while the final bit of the current mode is driven
//   o_crc_en                CRC block enable
//   o_crc_data_valid        one-cycle pulse, o_crc_data_out valid
//   o_crc_data_out          byte just loaded for transmission
//   o_crc_last_byte         one-cycle pulse, end of CRC frame
module ddr_tx (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_ddrccc_tx_en,
  input  logic [3:0] i_ddrccc_tx_mode,
  input  logic [7:0] i_regf_tx_data,
  input  logic [4:0] i_crc_value,
  output logic       o_sdahnd_tx_sda,
  output logic       o_ddrccc_tx_mode_done,
  output logic       o_crc_en,
  output logic       o_crc_data_valid,
  output logic [7:0] o_crc_data_out,
  output logic       o_crc_last_byte
);

  localparam logic [3:0] PREAMBLE_ONE  = 4'd0;
  localparam logic [3:0] PREAMBLE_ZERO = 4'd1;
  localparam logic [3:0] SERIAL_BYTE   = 4'd2;
  localparam logic [3:0] PARITY        = 4'd3;
  localparam logic [3:0] CRC_TOKEN     = 4'd4;
  localparam logic [3:0] CRC_VALUE     = 4'd5;

  // Index of the final bit of each mode.
  function automatic logic [2:0] mode_last(input logic [3:0] m);
    case (m)
      SERIAL_BYTE: mode_last = 3'd7;
      PARITY:      mode_last = 3'd1;
      CRC_TOKEN:   mode_last = 3'd3;
      CRC_VALUE:   mode_last = 3'd4;
      default:     mode_last = 3'd0;
    endcase
  endfunction

  function automatic logic mode_ok(input logic [3:0] m);
    mode_ok = (m <= CRC_VALUE);
  endfunction

  logic        en_q, en_d;
  logic [3:0]  mode_q, mode_d;
  logic [7:0]  pay_q, pay_d;       // left-aligned shift register, bit 7 is on SDA
  logic [2:0]  cnt_q, cnt_d;
  logic        idx_q, idx_d;
  logic [15:0] w_q, w_d;
  logic        sda_q, sda_d;
  logic        done_q, done_d;
  logic        crc_en_q, crc_en_d;
  logic        valid_q, valid_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        lastb_q, lastb_d;

  logic scl_edge, rise, ending, idx_nx;
  logic p1, p0;

  assign p1 = ^(w_q & 16'hAAAA);
  assign p0 = ~^(w_q & 16'h5555);

  always_comb begin
    en_d     = i_ddrccc_tx_en;
    mode_d   = mode_q;
    pay_d    = pay_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    w_d      = w_q;
    sda_d    = sda_q;
    done_d   = done_q;
    crc_en_d = crc_en_q;
    valid_d  = 1'b0;
    cdata_d  = cdata_q;
    lastb_d  = 1'b0;
    idx_nx   = idx_q;

    scl_edge = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    rise     = i_ddrccc_tx_en & ~en_q;
    // An unsupported mode has no bits to count, so any edge lets the
    // controller replace it.
    ending   = scl_edge & (~mode_ok(mode_q) | (cnt_q == mode_last(mode_q)));

    if (!i_ddrccc_tx_en) begin
      sda_d    = 1'b1;
      cnt_d    = 3'd0;
      idx_d    = 1'b0;
      done_d   = 1'b0;
      crc_en_d = 1'b0;
    end else if (rise || ending) begin
      // Completion effects of the mode that just ended (not on a fresh enable).
      if (!rise && mode_q == PARITY)    idx_nx   = 1'b0;
      if (!rise && mode_q == CRC_VALUE) crc_en_d = 1'b0;

      mode_d = i_ddrccc_tx_mode;
      cnt_d  = 3'd0;
      case (i_ddrccc_tx_mode)
        PREAMBLE_ONE:  pay_d = 8'h80;
        PREAMBLE_ZERO: pay_d = 8'h00;
        SERIAL_BYTE: begin
          pay_d = i_regf_tx_data;
          if (idx_nx) w_d[7:0]  = i_regf_tx_data;
          else        w_d[15:8] = i_regf_tx_data;
          idx_nx   = ~idx_nx;
          crc_en_d = 1'b1;
          valid_d  = 1'b1;
          cdata_d  = i_regf_tx_data;
        end
        PARITY:        pay_d = {p1, p0, 6'b0};
        CRC_TOKEN: begin
          pay_d   = 8'hC0;
          lastb_d = 1'b1;
        end
        CRC_VALUE:     pay_d = {i_crc_value, 3'b0};
        default:       pay_d = 8'hFF;
      endcase
      idx_d  = idx_nx;
      sda_d  = pay_d[7];
      done_d = mode_ok(i_ddrccc_tx_mode) && (mode_last(i_ddrccc_tx_mode) == 3'd0);
    end else if (scl_edge) begin
      cnt_d  = cnt_q + 3'd1;
      pay_d  = {pay_q[6:0], 1'b0};
      sda_d  = pay_d[7];
      done_d = (cnt_d == mode_last(mode_q));
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      en_q     <= 1'b0;
      mode_q   <= 4'd0;
      pay_q    <= 8'd0;
      cnt_q    <= 3'd0;
      idx_q    <= 1'b0;
      w_q      <= 16'd0;
      sda_q    <= 1'b1;
      done_q   <= 1'b0;
      crc_en_q <= 1'b0;
      valid_q  <= 1'b0;
      cdata_q  <= 8'd0;
      lastb_q  <= 1'b0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      pay_q    <= pay_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      sda_q    <= sda_d;
      done_q   <= done_d;
      crc_en_q <= crc_en_d;
      valid_q  <= valid_d;
      cdata_q  <= cdata_d;
      lastb_q  <= lastb_d;
    end
  end

  assign o_sdahnd_tx_sda       = sda_q;
  assign o_ddrccc_tx_mode_done = done_q;
  assign o_crc_en              = crc_en_q;
  assign o_crc_data_valid      = valid_q;
  assign o_crc_data_out        = cdata_q;
  assign o_crc_last_byte       = lastb_q;

endmodule

// File: tb/tb_ddr_tx.sv
// tb/tb_ddr_tx.sv - directed self-checking bench for ddr_tx
module tb_ddr_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       pos, neg;
  logic       tx_en;
  logic [3:0] mode;
  logic [7:0] data;
  logic [4:0] crc;
  logic       sda, done, crc_en, valid, lastb;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;
  bit pos_nxt = 1'b1;

  always #5 clk = ~clk;

  ddr_tx dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_ddrccc_tx_en        (tx_en),
    .i_ddrccc_tx_mode      (mode),
    .i_regf_tx_data        (data),
    .i_crc_value           (crc),
    .o_sdahnd_tx_sda       (sda),
    .o_ddrccc_tx_mode_done (done),
    .o_crc_en              (crc_en),
    .o_crc_data_valid      (valid),
    .o_crc_data_out        (dout),
    .o_crc_last_byte       (lastb)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Alternates rising/falling SCL pulses.
  task automatic pulse();
    if (pos_nxt) pos = 1'b1;
    else         neg = 1'b1;
    pos_nxt = ~pos_nxt;
    step();
    pos = 1'b0;
    neg = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sda"},    {15'd0, sda},    16'd1);
    chk({tag, " done"},   {15'd0, done},   16'd0);
    chk({tag, " crc_en"}, {15'd0, crc_en}, 16'd0);
    chk({tag, " valid"},  {15'd0, valid},  16'd0);
    chk({tag, " dout"},   {8'd0, dout},    16'd0);
    chk({tag, " last"},   {15'd0, lastb},  16'd0);
  endtask

  // Checks n bits (left-aligned in bits). Bit 0 is loaded either by an
  // SCL pulse or by the enable rising edge (plain clock).
  task automatic expect_bits(input string tag, input logic [7:0] bits, input int n,
                             input bit via_edge, input bit v0, input logic [7:0] d0,
                             input bit l0);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && !via_edge) step();
      else                     pulse();
      chk($sformatf("%s sda bit%0d", tag, i), {15'd0, sda}, {15'd0, bits[7-i]});
      chk($sformatf("%s done bit%0d", tag, i), {15'd0, done}, {15'd0, (i == n-1)});
      chk($sformatf("%s valid bit%0d", tag, i), {15'd0, valid}, {15'd0, (i == 0) ? v0 : 1'b0});
      chk($sformatf("%s last bit%0d", tag, i), {15'd0, lastb}, {15'd0, (i == 0) ? l0 : 1'b0});
      if (i == 0 && v0) chk({tag, " dout"}, {8'd0, dout}, {8'd0, d0});
    end
  endtask

  initial begin
    logic [7:0] ab;
    rst = 1'b0; pos = 1'b0; neg = 1'b0; tx_en = 1'b0;
    mode = 4'd0; data = 8'd0; crc = 5'd0;
    #12;
    chk_reset("reset");
    rst = 1'b1;
    step();

    // Frame 1: preamble 0, A5, 3C, parity, token, CRC 10110.
    tx_en = 1'b1; mode = 4'd1;
    expect_bits("pre0", 8'h00, 1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre0 crc_en", {15'd0, crc_en}, 16'd0);
    mode = 4'd2; data = 8'hA5;
    expect_bits("byteA5", 8'hA5, 8, 1'b1, 1'b1, 8'hA5, 1'b0);
    chk("byteA5 crc_en", {15'd0, crc_en}, 16'd1);
    data = 8'h3C;
    expect_bits("byte3C", 8'h3C, 8, 1'b1, 1'b1, 8'h3C, 1'b0);
    mode = 4'd3;
    expect_bits("parityA53C", 8'h40, 2, 1'b1, 1'b0, 8'h00, 1'b0);
    mode = 4'd4;
    expect_bits("token", 8'hC0, 4, 1'b1, 1'b0, 8'h00, 1'b1);
    mode = 4'd5; crc = 5'b10110;
    expect_bits("crcval", 8'hB0, 5, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("crcval crc_en last bit", {15'd0, crc_en}, 16'd1);

    // Unsupported mode: SDA idles high, never done.
    mode = 4'd9;
    for (int i = 0; i < 4; i++) begin
      pulse();
      chk($sformatf("mode9 sda %0d", i), {15'd0, sda}, 16'd1);
      chk($sformatf("mode9 done %0d", i), {15'd0, done}, 16'd0);
    end
    chk("crc_en after crcval", {15'd0, crc_en}, 16'd0);
    chk("dout hold", {8'd0, dout}, 16'h003C);

    // Abort during bit 4 of byte 5A, then re-enable.
    mode = 4'd2; data = 8'h5A; ab = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      pulse();
      chk($sformatf("abort sda bit%0d", i), {15'd0, sda}, {15'd0, ab[7-i]});
    end
    tx_en = 1'b0;
    step();
    chk("abort sda", {15'd0, sda}, 16'd1);
    chk("abort done", {15'd0, done}, 16'd0);
    chk("abort crc_en", {15'd0, crc_en}, 16'd0);
    chk("abort dout hold", {8'd0, dout}, 16'h005A);
    tx_en = 1'b1;
    expect_bits("reen", 8'h5A, 8, 1'b0, 1'b1, 8'h5A, 1'b0);

    // Asynchronous reset during CRC_VALUE.
    mode = 4'd4;
    expect_bits("tok2", 8'hC0, 4, 1'b1, 1'b0, 8'h00, 1'b1);
    mode = 4'd5; crc = 5'b10110;
    pulse();
    chk("crc2 bit0", {15'd0, sda}, 16'd1);
    pulse();
    chk("crc2 bit1", {15'd0, sda}, 16'd0);
    #2;
    rst = 1'b0; tx_en = 1'b0;
    #1;
    chk_reset("async");
    step();
    rst = 1'b1;
    step();

    // Frame 2: preamble 0, 81, 7F, parity (W=817F -> P1=0, P0=0), token, CRC 01001.
    tx_en = 1'b1; mode = 4'd1;
    expect_bits("f2pre0", 8'h00, 1, 1'b0, 1'b0, 8'h00, 1'b0);
    mode = 4'd2; data = 8'h81;
    expect_bits("byte81", 8'h81, 8, 1'b1, 1'b1, 8'h81, 1'b0);
    data = 8'h7F;
    expect_bits("byte7F", 8'h7F, 8, 1'b1, 1'b1, 8'h7F, 1'b0);
    mode = 4'd3;
    expect_bits("parity817F", 8'h00, 2, 1'b1, 1'b0, 8'h00, 1'b0);
    mode = 4'd4;
    expect_bits("f2token", 8'hC0, 4, 1'b1, 1'b0, 8'h00, 1'b1);
    mode = 4'd5; crc = 5'b01001;
    expect_bits("f2crc", 8'h48, 5, 1'b1, 1'b0, 8'h00, 1'b0);
    mode = 4'd0;
    expect_bits("pre1", 8'h80, 1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("f2 crc_en end", {15'd0, crc_en}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_tx.md
# ddr_tx

HDR-DDR serializer for the controller side of the I3C data path; the transmit counterpart of the DDR receiver. On SCL edge pulses from the SCL generator it drives the SDA handler with preamble bits, MSB-first data bytes, the two per-word parity bits, the CRC token (4'hC) and the 5-bit CRC value, as selected by the DDR CCC controller's tx mode. It also feeds transmitted bytes to the CRC block.

## Interface
Parameters:
- none; fixed widths: 8-bit data, 5-bit CRC, 4-bit mode.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst  in  1  reset, asynchronous, active-low
- i_sclgen_scl_pos_edge  in  1  one-cycle pulse per SCL rising edge
- i_sclgen_scl_neg_edge  in  1  one-cycle pulse per SCL falling edge
- i_ddrccc_tx_en  in  1  block enable
- i_ddrccc_tx_mode  in  4  bit-field to transmit
- i_regf_tx_data  in  8  byte for SERIAL_BYTE, from register file
- i_crc_value  in  5  CRC result for CRC_VALUE
- o_sdahnd_tx_sda  out  1  serial bit to SDA handler
- o_ddrccc_tx_mode_done  out  1  level: final bit of current mode on SDA
- o_crc_en  out  1  CRC block enable
- o_crc_data_valid  out  1  one-cycle pulse: o_crc_data_out valid
- o_crc_data_out  out  8  byte just loaded for transmission
- o_crc_last_byte  out  1  one-cycle pulse: no more bytes in CRC frame

## Operation
- Modes (bit count, content, all MSB first):
  - 4'd0 PREAMBLE_ONE: 1 bit, '1'.
  - 4'd1 PREAMBLE_ZERO: 1 bit, '0'.
  - 4'd2 SERIAL_BYTE: 8 bits of i_regf_tx_data, latched into a shift register at load.
  - 4'd3 PARITY: 2 bits, P1 then P0, computed over the 16-bit word W = {byte0, byte1} of the last two bytes sent: P1 = XOR of W[15,13,...,1]; P0 = XOR of W[14,12,...,0] XOR 1.
  - 4'd4 CRC_TOKEN: 4 bits, 4'b1100.
  - 4'd5 CRC_VALUE: 5 bits of i_crc_value, latched at load.
  - any other value: SDA = 1, no count, done = 0.
- "Load" = put bit 0 of the mode on SDA, bit counter = 0. Load occurs on the first cycle i_ddrccc_tx_en is high (rising-edge detect), and on every SCL edge pulse that ends the final bit of a mode, using i_ddrccc_tx_mode/i_regf_tx_data/i_crc_value sampled that cycle.
- Any SCL edge pulse (pos or neg) that does not end a mode advances the counter and drives the next bit.
- Byte index toggles on each SERIAL_BYTE load: index 0 writes W[15:8], index 1 writes W[7:0]. Index clears on PARITY completion.
- CRC: o_crc_en high from the first SERIAL_BYTE load until CRC_VALUE completes. On SERIAL_BYTE load: o_crc_data_valid = 1 for one cycle, o_crc_data_out = byte. On CRC_TOKEN load: o_crc_last_byte = 1 for one cycle.
- i_ddrccc_tx_en low: SDA = 1, counter = 0, byte index = 0, done = 0, CRC outputs = 0. Register contents W and o_crc_data_out hold their values.

## Timing
- Reset values: o_sdahnd_tx_sda = 1, o_ddrccc_tx_mode_done = 0, o_crc_en = 0, o_crc_data_valid = 0, o_crc_data_out = 0, o_crc_last_byte = 0. Internal counter, byte index and W are 0.
- All outputs are registered. SDA changes 1 i_sys_clk after the edge pulse.
- Done timing: done rises the cycle the final bit is driven. For 1-bit modes this is the load cycle. It falls on the cycle after the ending edge, unless the newly loaded mode is also 1 bit.
- The controller must present the next mode, together with valid data/CRC, no later than the cycle of the ending edge pulse. Back-to-back modes then leave no gap.
- Parity: PARITY uses W as it stands at PARITY load. That W includes the byte loaded on the same edge only if that byte was loaded earlier; in normal order, both bytes are sent before PARITY.
- Pos and neg pulses are never simultaneous. If both arrive in the same cycle, treat them as a single edge.
- tx_en deassert mid-mode aborts immediately, SDA = 1 next cycle. Re-enable restarts at bit 0.
- Asynchronous reset mid-mode: all outputs take their reset values immediately.

## Test plan
- Enable with mode 1 -> SDA = 0, done = 1 in the load cycle. Then an edge with mode switched to 2, data 8'hA5 -> SDA shows 1,0,1,0,0,1,0,1 on successive edges; done is high only during the last bit.
- Bytes 8'hA5 then 8'h3C, then PARITY -> W = 16'hA53C, SDA shows P1 = 0, P0 = 1. o_crc_data_valid pulses twice, with o_crc_data_out = A5 then 3C.
- CRC_TOKEN then CRC_VALUE with i_crc_value = 5'b10110 -> SDA shows 1,1,0,0,1,0,1,1,0. o_crc_last_byte pulses at token load. o_crc_en drops after the final bit.
- tx_en dropped during bit 4 of a byte -> SDA = 1 and done = 0 next cycle. Re-enable -> bit 0 (MSB) is driven again.
- Asynchronous reset during CRC_VALUE -> all outputs take their reset values without waiting for a clock edge. A following full frame is transmitted correctly.
- Mode 4'd9 -> SDA stays 1, done never asserts, regardless of edge pulses.
